// File: rtl/weights_fetch_pkg.sv
// Shared definitions for the weights fetch engine: FSM state encoding and
// default geometry of the attached weights ROM.
package weights_fetch_pkg;

    localparam int WF_W_DATA      = 3;
    localparam int WF_W_ADDR      = 8;
    localparam int WF_FEATURE_NUM = 136;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } wf_state_e;

endpackage

// File: rtl/weights_skid_fifo.sv
// Two-entry output FIFO with fall-through: when empty, a pushed word is
// presented on the output in the same cycle it arrives.
module weights_skid_fifo #(
    parameter int W_DATA = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [W_DATA-1:0] i_push_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [W_DATA-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [W_DATA-1:0] r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              w_empty;
    logic              w_store;
    logic              w_deq;

    // Output selection and push/pop decisions; a bypassed word consumed at once is never stored
    always_comb begin
        w_empty = (r_count == 2'd0);
        o_valid = !w_empty || i_push;
        if (!w_empty) begin
            o_data = r_mem[r_rd_ptr];
        end else if (i_push) begin
            o_data = i_push_data;
        end else begin
            o_data = {W_DATA{1'b0}};
        end
        w_deq   = o_valid && i_ready && !w_empty;
        w_store = i_push && !(w_empty && i_ready);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= {W_DATA{1'b0}};
            r_mem[1] <= {W_DATA{1'b0}};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/weights_fetch.sv
// Fetches a run of weights from a 1-cycle-latency ROM and streams them out.
// Optional macro WEIGHTS_FETCH_RANGE_CHK_EN adds an err output for runs past FEATURE_NUM.
module weights_fetch
    import weights_fetch_pkg::*;
#(
    parameter int W_DATA      = WF_W_DATA,
    parameter int W_ADDR      = WF_W_ADDR,
    parameter int FEATURE_NUM = WF_FEATURE_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_ADDR-1:0] start_addr,
    input  logic [W_ADDR:0]   feature_cnt,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [W_ADDR-1:0] rom_addr,
    input  logic [W_DATA-1:0] rom_data,
    output logic [W_DATA-1:0] weight_data,
    output logic              weight_valid,
    input  logic              weight_ready,
    output logic              weight_last
`ifdef WEIGHTS_FETCH_RANGE_CHK_EN
    ,
    output logic              err
`endif
);

    wf_state_e         r_state;
    wf_state_e         w_next_state;
    logic [W_ADDR-1:0] r_addr;
    logic [W_ADDR:0]   r_reads_left;
    logic [W_ADDR:0]   r_beats_left;
    logic              r_inflight;
    logic              r_zero_done;
    logic              w_accept;
    logic              w_go;
    logic              w_zero;
    logic              w_range_bad;
    logic              w_credit_ok;
    logic              w_rom_en;
    logic              w_last;
    logic              w_pop;
    logic              w_fifo_valid;
    logic [1:0]        w_fifo_count;
    logic [W_DATA-1:0] w_fifo_data;

`ifdef WEIGHTS_FETCH_RANGE_CHK_EN
    logic [W_ADDR+1:0] w_run_end;
    logic              r_err;

    assign w_run_end   = {2'b00, start_addr} + {1'b0, feature_cnt};
    assign w_range_bad = (w_run_end > (W_ADDR+2)'(FEATURE_NUM));

    // A rejected start is reported one cycle later and leaves the FSM idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= start && (r_state == ST_IDLE) && w_range_bad;
        end
    end

    assign err = r_err;
`else
    assign w_range_bad = 1'b0;
`endif

    // Request acceptance, read credit, last-beat detection and next state
    always_comb begin
        w_accept    = start && (r_state == ST_IDLE);
        w_go        = w_accept && !w_range_bad && (feature_cnt != {(W_ADDR+1){1'b0}});
        w_zero      = w_accept && !w_range_bad && (feature_cnt == {(W_ADDR+1){1'b0}});
        // Occupancy plus the read in flight bounds what can still land in the FIFO
        w_credit_ok = (w_fifo_count + {1'b0, r_inflight}) < 2'd2;
        w_rom_en    = (r_state == ST_FETCH) && w_credit_ok;
        w_last      = w_fifo_valid && (r_beats_left == {{W_ADDR{1'b0}}, 1'b1});
        w_pop       = w_fifo_valid && weight_ready;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_rom_en && (r_reads_left == {{W_ADDR{1'b0}}, 1'b1})) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state, read address/counters and beat countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= {W_ADDR{1'b0}};
            r_reads_left <= {(W_ADDR+1){1'b0}};
            r_beats_left <= {(W_ADDR+1){1'b0}};
            r_inflight   <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_inflight  <= w_rom_en;
            r_zero_done <= w_zero;
            if (w_go) begin
                r_addr       <= start_addr;
                r_reads_left <= feature_cnt;
                r_beats_left <= feature_cnt;
            end else begin
                if (w_rom_en) begin
                    r_addr       <= r_addr + {{(W_ADDR-1){1'b0}}, 1'b1};
                    r_reads_left <= r_reads_left - {{W_ADDR{1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_beats_left <= r_beats_left - {{W_ADDR{1'b0}}, 1'b1};
                end
            end
        end
    end

    weights_skid_fifo #(
        .W_DATA (W_DATA)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (rom_data),
        .i_ready     (weight_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_count)
    );

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_zero_done || (w_pop && w_last);
    assign rom_en       = w_rom_en;
    assign rom_addr     = w_rom_en ? r_addr : {W_ADDR{1'b0}};
    assign weight_data  = w_fifo_data;
    assign weight_valid = w_fifo_valid;
    assign weight_last  = w_last;

endmodule

// File: tb/tb_weights_fetch.sv
// Randomized self-checking bench for weights_fetch against a queue-based
// reference of the expected beat stream and a ROM behavioural model.
module tb_weights_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] feature_cnt;
    logic       busy;
    logic       done;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [2:0] rom_data = 3'd0;
    logic [2:0] weight_data;
    logic       weight_valid;
    logic       weight_ready;
    logic       weight_last;
`ifdef WEIGHTS_FETCH_RANGE_CHK_EN
    logic       err;
`endif

    logic [2:0] rom [256];
    logic [2:0] exp_q [$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issued = 0;
    int xfers = 0;
    int dones = 0;
    int valids = 0;
    int first_valid_cyc = 0;
    int last_beat_cyc = 0;
    int done_cyc = 0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [2:0] prev_data = 3'd0;
    logic       prev_last = 1'b0;

    weights_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .feature_cnt  (feature_cnt),
        .busy         (busy),
        .done         (done),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .weight_data  (weight_data),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .weight_last  (weight_last)
`ifdef WEIGHTS_FETCH_RANGE_CHK_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: registered read, data visible the cycle after rom_en
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stream monitor: credit, hold stability, beat order, last and done
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            issued     = xfers;
        end else begin
            if (rom_en) begin
                check_eq("credit", 32'((issued - xfers) < 2), 32'd1);
                issued++;
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(weight_valid), 32'd1);
                check_eq("hold_data", 32'(weight_data), 32'(prev_data));
                check_eq("hold_last", 32'(weight_last), 32'(prev_last));
            end
            if (weight_valid) begin
                valids++;
                if (!prev_valid) first_valid_cyc = cyc;
            end
            if (weight_valid && weight_ready) begin
                check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check_eq("beat_data", 32'(weight_data), 32'(e));
                    check_eq("beat_last", 32'(weight_last), 32'(exp_q.size() == 0));
                    check_eq("done_w_last", 32'(done), 32'(exp_q.size() == 0));
                end
                xfers++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            prev_stall = weight_valid && !weight_ready;
            prev_valid = weight_valid;
            prev_data  = weight_data;
            prev_last  = weight_last;
        end
    end

    // mode 0: ready high, 1: ready toggles, 2: random ready; inject_at >= 0 fires a stray start
    task automatic run_case(input logic [7:0] addr, input logic [8:0] cnt, input int mode,
                            input int inject_at);
        int  b0, d0, i0, v0, cs;
        bit  fin;
        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(rom[8'(int'(addr) + i)]);
        b0 = xfers; d0 = dones; i0 = issued; v0 = valids; fin = 1'b0;
        start = 1'b1; start_addr = addr; feature_cnt = cnt; weight_ready = 1'b1;
        cs = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'(cnt != 9'd0));
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k == inject_at) begin
                start = 1'b1; start_addr = 8'h05; feature_cnt = 9'd4;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       weight_ready = 1'b1;
                1:       weight_ready = (k % 2 == 1);
                default: weight_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            if (dones != d0 && !busy) fin = 1'b1;
        end
        start = 1'b0; weight_ready = 1'b1;
        check_eq("run_dones", 32'(dones - d0), 32'd1);
        check_eq("run_beats", 32'(xfers - b0), 32'(cnt));
        check_eq("run_reads", 32'(issued - i0), 32'(cnt));
        check_eq("idle_after", 32'(busy), 32'd0);
        if (cnt == 9'd0) begin
            check_eq("zero_done_lat", 32'(done_cyc - cs), 32'd1);
            check_eq("zero_no_valid", 32'(valids - v0), 32'd0);
        end else if (mode == 0) begin
            check_eq("first_valid_lat", 32'(first_valid_cyc - cs), 32'd2);
            check_eq("throughput", 32'(last_beat_cyc - first_valid_cyc), 32'(cnt) - 32'd1);
        end
    endtask

    initial begin
        int b0, b1, d1;
        for (int i = 0; i < 256; i++) rom[i] = 3'd0;
        rom[8'h23] = 3'd2;
        rom[8'h30] = 3'd2;
        rst = 1'b0; start = 1'b0; start_addr = 8'd0; feature_cnt = 9'd0; weight_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rom_en", 32'(rom_en), 32'd0);
        check_eq("rst_valid", 32'(weight_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_case(8'h22, 9'd3, 0, -1);
        run_case(8'h30, 9'd4, 1, -1);
        run_case(8'h10, 9'd0, 0, -1);
        run_case(8'h40, 9'd8, 0, 2);

        for (int i = 0; i < 256; i++) rom[i] = 3'($urandom_range(0, 7));

        // Abort a run of 10 after three beats
        for (int i = 0; i < 10; i++) exp_q.push_back(rom[8'h40 + i]);
        b0 = xfers;
        start = 1'b1; start_addr = 8'h40; feature_cnt = 9'd10; weight_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50 && (xfers - b0) < 3; k++) begin
            @(posedge clk); #1;
        end
        check_eq("abort_beats_before", 32'(xfers - b0), 32'd3);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_rom_en", 32'(rom_en), 32'd0);
        check_eq("abort_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("abort_valid", 32'(weight_valid), 32'd0);
        check_eq("abort_last", 32'(weight_last), 32'd0);
        check_eq("abort_data", 32'(weight_data), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        b1 = xfers; d1 = dones;
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_abort_beats", 32'(xfers - b1), 32'd0);
        check_eq("post_abort_done", 32'(dones - d1), 32'd0);

`ifdef WEIGHTS_FETCH_RANGE_CHK_EN
        b1 = issued; d1 = dones;
        start = 1'b1; start_addr = 8'h80; feature_cnt = 9'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("err_pulse", 32'(err), 32'd1);
        check_eq("err_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq("err_one_cycle", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_no_reads", 32'(issued - b1), 32'd0);
        check_eq("err_no_done", 32'(dones - d1), 32'd0);
        run_case(8'h80, 9'd8, 0, -1);
`else
        run_case(8'hFD, 9'd6, 2, -1);
`endif

        for (int r = 0; r < 12; r++) begin
            run_case(8'($urandom_range(0, 120)), 9'($urandom_range(1, 16)),
                     int'($urandom_range(0, 2)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
